// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared constants and helpers for the CDB arbiter
package cdb_arbiter_pkg;

  localparam int CDB_N_REQ       = 3;
  localparam int CDB_ROB_ID_W    = 5;
  localparam int CDB_Q_DEPTH_BIT = 1;
  localparam int CDB_SRC_W       = 2;

  typedef enum logic [CDB_SRC_W-1:0] {
    CDB_SRC_ALU = 2'd0,
    CDB_SRC_LSB = 2'd1,
    CDB_SRC_BR  = 2'd2
  } cdb_src_e;

  // Index wrap for the round-robin scan; idx is always below 2*n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// rtl/cdb_req_fifo.sv - per-requester result FIFO holding {rob_id, val}
module cdb_req_fifo #(
  parameter int ROB_ID_W  = 5,
  parameter int DEPTH_BIT = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [ROB_ID_W-1:0] push_rob_id,
  input  logic [31:0]         push_val,
  output logic                full,
  output logic                empty,
  output logic [ROB_ID_W-1:0] head_rob_id,
  output logic [31:0]         head_val
);

  localparam int DEPTH = 1 << DEPTH_BIT;

  logic [ROB_ID_W+31:0]  mem [DEPTH];
  logic [DEPTH_BIT-1:0]  head;
  logic [DEPTH_BIT-1:0]  tail;
  logic [DEPTH_BIT:0]    count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (DEPTH_BIT+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign {head_rob_id, head_val} = mem[head];

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[tail] <= {push_rob_id, push_val};
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the registered common data bus
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ       = CDB_N_REQ,
  parameter int ROB_ID_W    = CDB_ROB_ID_W,
  parameter int Q_DEPTH_BIT = CDB_Q_DEPTH_BIT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear_flag,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ROB_ID_W-1:0] req_rob_id,
  input  logic [N_REQ*32-1:0]       req_val,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cdb_valid,
  output logic [ROB_ID_W-1:0]       cdb_rob_id,
  output logic [31:0]               cdb_val,
  output logic [CDB_SRC_W-1:0]      cdb_src
);

  logic [N_REQ-1:0]     full;
  logic [N_REQ-1:0]     empty;
  logic [N_REQ-1:0]     push;
  logic [N_REQ-1:0]     pop;
  logic [ROB_ID_W-1:0]  head_rob_id [N_REQ];
  logic [31:0]          head_val    [N_REQ];
  logic [CDB_SRC_W-1:0] rr_ptr;
  logic [CDB_SRC_W-1:0] grant_idx;
  logic [CDB_SRC_W-1:0] cand;
  logic                 grant_found;

  // A full FIFO is never ready, so a simultaneous pop cannot make room.
  assign req_ready = {N_REQ{rdy_in}} & ~full;
  assign push      = req_valid & req_ready & {N_REQ{~clear_flag}};

  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    cdb_req_fifo #(
      .ROB_ID_W  (ROB_ID_W),
      .DEPTH_BIT (Q_DEPTH_BIT)
    ) u_fifo (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .flush       (clear_flag),
      .push        (push[i]),
      .pop         (pop[i]),
      .push_rob_id (req_rob_id[i*ROB_ID_W +: ROB_ID_W]),
      .push_val    (req_val[i*32 +: 32]),
      .full        (full[i]),
      .empty       (empty[i]),
      .head_rob_id (head_rob_id[i]),
      .head_val    (head_val[i])
    );
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = CDB_SRC_W'(rr_wrap(int'(rr_ptr) + k, N_REQ));
      if (!grant_found && !empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant_found && rdy_in && !clear_flag) begin
      pop[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in || clear_flag) begin
      rr_ptr     <= '0;
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      cdb_src    <= CDB_SRC_ALU;
    end else if (rdy_in) begin
      if (grant_found) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= head_rob_id[grant_idx];
        cdb_val    <= head_val[grant_idx];
        cdb_src    <= grant_idx;
        rr_ptr     <= CDB_SRC_W'(rr_wrap(int'(grant_idx) + 1, N_REQ));
      end else begin
        cdb_valid  <= 1'b0;
        cdb_rob_id <= '0;
        cdb_val    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_flag;
  logic [2:0]  req_valid;
  logic [14:0] req_rob_id;
  logic [95:0] req_val;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_id;
  logic [31:0] cdb_val;
  logic [1:0]  cdb_src;

  cdb_arbiter dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear_flag (clear_flag),
    .req_valid  (req_valid),
    .req_rob_id (req_rob_id),
    .req_val    (req_val),
    .req_ready  (req_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_val    (cdb_val),
    .cdb_src    (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, clr, rdy;
    logic [2:0]  v;
    logic [4:0]  r0, r1, r2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  e_ready;
    logic        e_valid;
    logic [4:0]  e_rob;
    logic [31:0] e_val;
    logic [1:0]  e_src;
  } vec_t;

  typedef struct {
    logic [4:0]  rob;
    logic [31:0] val;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per producer, a round-robin start index,
  // and the last value broadcast on the bus.
  ent_t        q [3][$];
  int          m_rr;
  logic        m_valid;
  logic [4:0]  m_rob;
  logic [31:0] m_val;
  logic [1:0]  m_src;
  logic        m_known;

  vec_t tab [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model_ready();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = rdy_in && (q[i].size() < 2);
    return r;
  endfunction

  task automatic model_step();
    bit   acc [3];
    int   g;
    int   i;
    ent_t e;
    if (!rst_in) begin
      for (int j = 0; j < 3; j++) q[j].delete();
      m_rr = 0; m_valid = 0; m_rob = 0; m_val = 0; m_src = 0; m_known = 1;
    end else if (clear_flag) begin
      for (int j = 0; j < 3; j++) q[j].delete();
      m_rr = 0; m_valid = 0; m_known = 0;
    end else if (rdy_in) begin
      for (int j = 0; j < 3; j++) acc[j] = req_valid[j] && (q[j].size() < 2);
      g = -1;
      for (int k = 0; k < 3; k++) begin
        i = (m_rr + k) % 3;
        if (g < 0 && q[i].size() > 0) g = i;
      end
      if (g >= 0) begin
        e = q[g].pop_front();
        m_valid = 1; m_rob = e.rob; m_val = e.val; m_src = 2'(g);
        m_rr = (g + 1) % 3;
      end else begin
        m_valid = 0; m_rob = 0; m_val = 0;
      end
      m_known = 1;
      for (int j = 0; j < 3; j++) begin
        if (acc[j]) begin
          e.rob = req_rob_id[j*5 +: 5];
          e.val = req_val[j*32 +: 32];
          q[j].push_back(e);
        end
      end
    end
  endtask

  task automatic drive(input vec_t t);
    rst_in     = t.rst;
    clear_flag = t.clr;
    rdy_in     = t.rdy;
    req_valid  = t.v;
    req_rob_id = {t.r2, t.r1, t.r0};
    req_val    = {t.d2, t.d1, t.d0};
  endtask

  function automatic vec_t mk(
    input logic rst, input logic clr, input logic rdy, input logic [2:0] v,
    input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
    input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
    input logic [2:0] er, input logic ev, input logic [4:0] erob,
    input logic [31:0] eval, input logic [1:0] esrc);
    vec_t t;
    t.rst = rst; t.clr = clr; t.rdy = rdy; t.v = v;
    t.r0 = r0; t.r1 = r1; t.r2 = r2; t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.e_ready = er; t.e_valid = ev; t.e_rob = erob; t.e_val = eval; t.e_src = esrc;
    return t;
  endfunction

  initial begin
    vec_t t;
    vec_t ridle;
    ridle = mk(1, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 0);

    // Reset state
    t = ridle; t.rst = 0;
    drive(t);
    repeat (2) begin
      model_step();
      @(posedge clk_in); #1;
    end
    check("reset_valid", 32'(cdb_valid), 0);
    check("reset_rob", 32'(cdb_rob_id), 0);
    check("reset_val", cdb_val, 0);
    check("reset_src", 32'(cdb_src), 0);

    // rst clr rdy v  r0 r1 r2  d0 d1 d2  ready valid rob val src
    tab.push_back(mk(1,0,1,3'b001, 3,0,0, 32'h11,0,0, 3'b111, 0,0,0,0));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 1,3,32'h11,0));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 0,0,0,0));
    tab.push_back(mk(0,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 0,0,0,0));
    tab.push_back(mk(1,0,1,3'b111, 1,2,3, 32'hA1,32'hA2,32'hA3, 3'b111, 0,0,0,0));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 1,1,32'hA1,0));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 1,2,32'hA2,1));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 1,3,32'hA3,2));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 0,0,0,0));
    tab.push_back(mk(1,0,1,3'b111, 4,5,6, 32'h104,32'h105,32'h106, 3'b111, 0,0,0,0));
    tab.push_back(mk(1,0,1,3'b111, 7,8,9, 32'h107,32'h108,32'h109, 3'b111, 1,4,32'h104,0));
    tab.push_back(mk(1,0,1,3'b111, 10,11,12, 32'h10A,32'h10B,32'h10C, 3'b001, 1,5,32'h105,1));
    tab.push_back(mk(1,1,1,3'b111, 13,14,15, 32'h10D,32'h10E,32'h10F, 3'b010, 0,0,0,0));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 0,0,0,0));
    tab.push_back(mk(1,0,0,3'b001, 16,0,0, 32'h160,0,0, 3'b000, 0,0,0,0));
    tab.push_back(mk(1,0,1,3'b001, 20,0,0, 32'h200,0,0, 3'b111, 0,0,0,0));
    tab.push_back(mk(1,0,0,3'b000, 0,0,0, 0,0,0, 3'b000, 0,0,0,0));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 1,20,32'h200,0));
    tab.push_back(mk(1,0,0,3'b000, 0,0,0, 0,0,0, 3'b000, 1,20,32'h200,0));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 0,0,0,0));
    tab.push_back(mk(1,0,1,3'b110, 0,21,22, 0,32'h210,32'h220, 3'b111, 0,0,0,0));
    tab.push_back(mk(0,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 0,0,0,0));
    tab.push_back(mk(1,0,1,3'b101, 23,0,24, 32'h230,0,32'h240, 3'b111, 0,0,0,0));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 1,23,32'h230,0));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 1,24,32'h240,2));
    tab.push_back(mk(1,0,1,3'b000, 0,0,0, 0,0,0, 3'b111, 0,0,0,0));

    for (int n = 0; n < tab.size(); n++) begin
      drive(tab[n]);
      #1;
      check($sformatf("tab%0d_ready", n), 32'(req_ready), 32'(tab[n].e_ready));
      model_step();
      @(posedge clk_in); #1;
      check($sformatf("tab%0d_valid", n), 32'(cdb_valid), 32'(tab[n].e_valid));
      if (tab[n].e_valid) begin
        check($sformatf("tab%0d_rob", n), 32'(cdb_rob_id), 32'(tab[n].e_rob));
        check($sformatf("tab%0d_val", n), cdb_val, tab[n].e_val);
        check($sformatf("tab%0d_src", n), 32'(cdb_src), 32'(tab[n].e_src));
      end
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst_in     = ($urandom_range(0, 299) != 0);
      clear_flag = ($urandom_range(0, 59) == 0);
      rdy_in     = ($urandom_range(0, 99) < 85);
      req_valid  = 3'($urandom);
      req_rob_id = 15'($urandom);
      req_val    = {$urandom, $urandom, $urandom};
      #1;
      check($sformatf("rnd%0d_ready", c), 32'(req_ready), 32'(model_ready()));
      model_step();
      @(posedge clk_in); #1;
      check($sformatf("rnd%0d_valid", c), 32'(cdb_valid), 32'(m_valid));
      if (m_valid || m_known) begin
        check($sformatf("rnd%0d_rob", c), 32'(cdb_rob_id), 32'(m_rob));
        check($sformatf("rnd%0d_val", c), cdb_val, m_val);
      end
      if (m_valid) begin
        check($sformatf("rnd%0d_src", c), 32'(cdb_src), 32'(m_src));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
